bikelight_ctrl: RTL and testbench
=================================

Name: bikelight_ctrl

Overview:
Mode controller for the bike light. It takes the raw push-button and produces the LED drive.
- Synchronises and debounces the button.
- Advances a 4-state light-mode FSM on each debounced press.
- Generates the per-mode light waveform: off, steady, blink or PWM-dim.
- Exports the mode as one-hot and binary, so the board top can show it on status LEDs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button changes (>=1)
BLINK_HALF, 12500000, cycles per blink half-period (>=1)
PWM_PERIOD, 256, dim-mode PWM period in cycles (>=2)
DIM_ON, 32, dim-mode on-cycles per PWM period (0..PWM_PERIOD)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn  in  1  raw push-button, asynchronous to clk, active-high
light  out  1  LED drive
mode  out  2  current mode, binary: OFF=0, ON=1, BLINK=2, DIM=3
q  out  4  current mode, one-hot: q[i]=1 iff mode==i
press  out  1  one-cycle pulse on the edge where a debounced press is accepted

Behaviour:
- Reset (async assert, sync release) clears the following:
  - sync flops, debounced state, debounce counter, blink counter and PWM counter all = 0
  - mode=OFF, q=4'b0001, light=0, press=0
- Synchroniser: two flops on btn; only the second flop's output (btn_s) is used downstream.
- Debounce:
  - While btn_s != db_state, the counter increments each cycle.
  - When btn_s == db_state, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still differing, db_state flips and the counter clears on that edge.
  - Pulses shorter than DEBOUNCE_CYCLES cycles at btn_s are ignored entirely.
- Press detection:
  - press=1 for exactly the cycle after db_state goes 0->1 (registered).
  - A 1->0 transition produces no press.
  - Holding the button produces exactly one press.
- Latency: btn sampled high at edge k and held → db_state rises at edge k+1+DEBOUNCE_CYCLES, and mode changes on that same edge. press is high in the following cycle.
- Mode FSM: OFF→ON→BLINK→DIM→OFF, one step per accepted press, and no other transitions. mode and q are registered and change together.
- Light generation (light is registered):
  - OFF: light=0.
  - ON: light=1.
  - BLINK:
    - On entry, the blink counter = 0 and light=1.
    - The counter counts 0..BLINK_HALF-1; at BLINK_HALF-1 it wraps to 0 and light toggles.
  - DIM:
    - On entry, the PWM counter = 0.
    - The PWM counter counts 0..PWM_PERIOD-1 and wraps.
    - light = (pwm_cnt < DIM_ON).
    - DIM_ON=0 → light is constant 0; DIM_ON=PWM_PERIOD → light is constant 1.
- Counter scope: the blink and PWM counters hold at 0 outside their own mode, and restart from 0 on every entry to their mode.
- Light timing: light reflects the new mode starting the cycle after mode changes (one registered stage).
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible because every counter wraps or clears before its terminal count.
- Reset mid-operation:
  - Any state, including mid-debounce count or mid-blink, returns immediately to the reset values.
  - If btn is held high through reset release, it is treated as a fresh press: mode becomes ON after the debounce latency.
- Simultaneous events: a press accepted on the same edge a blink/PWM counter wraps → the mode change wins, and the new mode's counter starts from 0.

Decomposition:
- Shared package bikelight_pkg holds:
  - the mode encoding constants MODE_OFF/ON/BLINK/DIM (2-bit)
  - the mode count (4)
  - a next_mode function implementing the wrap order
- One sub-module, btn_debounce:
  - parameter: DEBOUNCE_CYCLES
  - ports: clk, rst, btn in; level and rise_pulse out
  - contains the synchroniser, debounce counter and rise detector
- Mode FSM and light generation live in bikelight_ctrl.
- Test parameters: DEBOUNCE_CYCLES=4, BLINK_HALF=3, PWM_PERIOD=4, DIM_ON=1.

Test Plan:
1. Reset then idle, btn=0 for 50 cycles → mode=0, q=0001, light=0, press never asserted.
2. btn high for 20 cycles, first sampled at edge k → mode=1 and q=0010 at edge k+5. press=1 for one cycle only. light=1 from the next cycle and stays 1.
3. Glitch test: btn high for 3 cycles then low → no press, and mode unchanged. Repeated 3-on/1-off bursts for 40 cycles → still no press.
4. Four clean presses, each 10 cycles high and 10 low → mode sequence 1,2,3,0.
   - BLINK: light pattern 1,1,1,0,0,0,1,...
   - DIM: light pattern 1,0,0,0 repeating.
   - Final mode OFF with light=0.
5. Enter BLINK, then assert rst asynchronously mid-cycle during a light=0 phase → mode=0, q=0001 and light=0 immediately, without waiting for a clock edge. btn held through release → mode=1 after 6 edges.
6. Press timed so mode changes on the edge of a blink wrap → DIM is entered with the PWM counter at 0, and the first light cycle in DIM =1.

Source files
------------

// File: rtl/bikelight_pkg.sv
// Shared definitions for the bike-light controller: mode encoding, mode count
// and the mode sequencing helpers.
package bikelight_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_t;

    localparam int MODE_COUNT = 4;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   next_mode = MODE_ON;
            MODE_ON:    next_mode = MODE_BLINK;
            MODE_BLINK: next_mode = MODE_DIM;
            default:    next_mode = MODE_OFF;
        endcase
    endfunction

    function automatic logic [MODE_COUNT-1:0] mode_onehot(input mode_t m);
        mode_onehot = MODE_COUNT'(1) << m;
    endfunction

endpackage

// File: rtl/bikelight_ctrl_btn_debounce.sv
// Button synchroniser and debouncer. rise_pulse is combinational: it is high in
// the cycle whose closing edge flips the debounced level from 0 to 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          btn_s;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip       = (btn_s != level) && (cnt == CNT_LAST);
    assign rise_pulse = flip && btn_s;

    // sync_p0 -> btn_s is the two-flop synchroniser; only btn_s feeds the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            btn_s   <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= btn;
            btn_s   <= sync_p0;
            if (btn_s == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bikelight_ctrl.sv
// Bike-light mode controller: debounced button steps a four-mode FSM, and a
// registered waveform generator drives the LED for the current mode.
module bikelight_ctrl
    import bikelight_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 12500000,
    parameter int PWM_PERIOD      = 256,
    parameter int DIM_ON          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       light,
    output logic [1:0] mode,
    output logic [3:0] q,
    output logic       press
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_PERIOD - 1);
    localparam logic [PW:0]   DIM_ON_L   = (PW + 1)'(DIM_ON);

    logic          db_level;
    logic          db_rise;
    logic          accept;
    mode_t         state_p0;
    mode_t         state_next;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic [PW-1:0] pwm_cnt;
    logic          pwm_on;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .level     (db_level),
        .rise_pulse(db_rise)
    );

    assign accept = db_rise && !db_level;
    assign mode   = state_p0;
    assign pwm_on = ({1'b0, pwm_cnt} < DIM_ON_L);

    // Mode register: advances on the same edge the debounced level rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= MODE_OFF;
            q        <= 4'b0001;
            press    <= 1'b0;
        end else begin
            state_p0 <= state_next;
            q        <= mode_onehot(state_next);
            press    <= accept;
        end
    end

    always_comb begin
        state_next = state_p0;
        if (accept) begin
            state_next = next_mode(state_p0);
        end
    end

    // Waveform stage: counters idle at 0 outside their mode, so every entry restarts them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            pwm_cnt   <= '0;
            light     <= 1'b0;
        end else begin
            if (state_p0 == MODE_BLINK && !accept) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                blink_ph  <= 1'b1;
            end

            if (state_p0 == MODE_DIM && !accept) begin
                pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            end else begin
                pwm_cnt <= '0;
            end

            case (state_p0)
                MODE_OFF:   light <= 1'b0;
                MODE_ON:    light <= 1'b1;
                MODE_BLINK: light <= blink_ph;
                MODE_DIM:   light <= pwm_on;
                default:    light <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bikelight_ctrl.sv
// Directed bench for bikelight_ctrl with small debounce/blink/PWM parameters.
module tb_bikelight_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       light;
    logic [1:0] mode;
    logic [3:0] q;
    logic       press;

    int tests = 0;
    int fails = 0;

    bikelight_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_HALF     (3),
        .PWM_PERIOD     (4),
        .DIM_ON         (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .light(light),
        .mode (mode),
        .q    (q),
        .press(press)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        btn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        btn = 1'b0;
        tick();
        tick();
        tests++;
        if (mode !== 2'd0 || q !== 4'b0001 || light !== 1'b0 || press !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got mode=%0d q=%b light=%b press=%b, expected mode=0 q=0001 light=0 press=0",
                     mode, q, light, press);
        end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (mode !== 2'd0 || q !== 4'b0001 || light !== 1'b0 || press !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle_50: got %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_single_press;
        int bad;
        bad = 0;
        btn = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            if (c == 21) btn = 1'b0;
            tick();
            if (c == 5) begin
                tests++;
                if (mode !== 2'd0) begin
                    fails++;
                    $display("FAIL press_early: got mode=%0d, expected 0", mode);
                end
            end else if (c == 6) begin
                tests++;
                if (mode !== 2'd1 || q !== 4'b0010 || press !== 1'b1 || light !== 1'b0) begin
                    fails++;
                    $display("FAIL press_edge: got mode=%0d q=%b press=%b light=%b, expected mode=1 q=0010 press=1 light=0",
                             mode, q, press, light);
                end
            end else if (c == 7) begin
                tests++;
                if (press !== 1'b0 || light !== 1'b1) begin
                    fails++;
                    $display("FAIL press_after: got press=%b light=%b, expected press=0 light=1", press, light);
                end
            end else if (c > 7) begin
                if (press !== 1'b0 || light !== 1'b1 || mode !== 2'd1 || q !== 4'b0010) bad++;
            end
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL press_hold_release: got %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_glitch;
        int presses;
        presses = 0;
        btn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) btn = 1'b0;
            tick();
            if (press === 1'b1) presses++;
        end
        tests++;
        if (presses !== 0 || mode !== 2'd1) begin
            fails++;
            $display("FAIL glitch_single: got presses=%0d mode=%0d, expected presses=0 mode=1", presses, mode);
        end
        for (int c = 0; c < 40; c++) begin
            btn = ((c % 4) != 3);
            tick();
            if (press === 1'b1) presses++;
        end
        btn = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (press === 1'b1) presses++;
        end
        tests++;
        if (presses !== 0 || mode !== 2'd1 || light !== 1'b1) begin
            fails++;
            $display("FAIL glitch_bursts: got presses=%0d mode=%0d light=%b, expected presses=0 mode=1 light=1",
                     presses, mode, light);
        end
    endtask

    task automatic test_mode_cycle;
        logic [1:0] exp_mode;
        logic [1:0] prev_mode;
        logic [7:0] pat;
        int         bad;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            prev_mode = 2'(p);
            exp_mode  = 2'(p + 1);
            case (p)
                0:       pat = 8'b1111_1111;
                1:       pat = 8'b1100_0111;
                2:       pat = 8'b0001_0001;
                default: pat = 8'b0000_0000;
            endcase
            bad = 0;
            btn = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                if (c == 11) btn = 1'b0;
                tick();
                if (c == 5) begin
                    tests++;
                    if (mode !== prev_mode) begin
                        fails++;
                        $display("FAIL cycle_before_%0d: got mode=%0d, expected %0d", p, mode, prev_mode);
                    end
                end else if (c == 6) begin
                    tests++;
                    if (mode !== exp_mode || press !== 1'b1) begin
                        fails++;
                        $display("FAIL cycle_step_%0d: got mode=%0d press=%b, expected mode=%0d press=1",
                                 p, mode, press, exp_mode);
                    end
                end else if (c > 6) begin
                    if (press !== 1'b0 || mode !== exp_mode) bad++;
                    if (c <= 14 && light !== pat[c-7]) bad++;
                end
            end
            tests++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL cycle_light_%0d: got %0d bad cycles, expected 0", p, bad);
            end
        end
        tests++;
        if (mode !== 2'd0 || q !== 4'b0001 || light !== 1'b0) begin
            fails++;
            $display("FAIL cycle_final: got mode=%0d q=%b light=%b, expected mode=0 q=0001 light=0", mode, q, light);
        end
    endtask

    task automatic test_async_reset;
        int waited;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            btn = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                if (c == 11) btn = 1'b0;
                tick();
            end
        end
        tests++;
        if (mode !== 2'd2) begin
            fails++;
            $display("FAIL areset_setup: got mode=%0d, expected 2", mode);
        end
        waited = 0;
        while (light !== 1'b0 && waited < 8) begin
            tick();
            waited++;
        end
        tests++;
        if (light !== 1'b0) begin
            fails++;
            $display("FAIL areset_dark_phase: got light=%b after %0d cycles, expected 0", light, waited);
        end
        #3;
        rst = 1'b1;
        btn = 1'b1;
        #1;
        tests++;
        if (mode !== 2'd0 || q !== 4'b0001 || light !== 1'b0 || press !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got mode=%0d q=%b light=%b press=%b, expected mode=0 q=0001 light=0 press=0",
                     mode, q, light, press);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) begin
                tests++;
                if (mode !== 2'd0) begin
                    fails++;
                    $display("FAIL areset_held_early: got mode=%0d, expected 0", mode);
                end
            end else if (c == 6) begin
                tests++;
                if (mode !== 2'd1 || q !== 4'b0010 || press !== 1'b1) begin
                    fails++;
                    $display("FAIL areset_held_press: got mode=%0d q=%b press=%b, expected mode=1 q=0010 press=1",
                             mode, q, press);
                end
            end
        end
        btn = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_wrap_collision;
        logic [3:0] dim_pat;
        int         bad;
        do_reset();
        btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 11) btn = 1'b0;
            tick();
        end
        dim_pat = 4'b0001;
        bad = 0;
        btn = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 11) btn = 1'b0;
            if (c == 19) btn = 1'b1;
            tick();
            if (c == 6 || c == 23) begin
                tests++;
                if (mode !== 2'd2) begin
                    fails++;
                    $display("FAIL wrap_blink_c%0d: got mode=%0d, expected 2", c, mode);
                end
            end else if (c == 24) begin
                tests++;
                if (mode !== 2'd3 || q !== 4'b1000 || press !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_enter_dim: got mode=%0d q=%b press=%b, expected mode=3 q=1000 press=1",
                             mode, q, press);
                end
            end else if (c == 25) begin
                tests++;
                if (light !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_first_dim: got light=%b, expected 1", light);
                end
            end else if (c > 25) begin
                if (light !== dim_pat[(c-25)%4]) bad++;
            end
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL wrap_dim_pattern: got %0d bad cycles, expected 0", bad);
        end
        btn = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_mode_cycle();
        test_async_reset();
        test_wrap_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
